// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the opcode map (instruction[7:4]), the sequencer state encoding and
// the default reset program counter. It also provides small opcode-class helpers.
package instr_sequencer_pkg;

  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_RSV6  = 4'h6;
  localparam logic [3:0] OP_RSV7  = 4'h7;
  localparam logic [3:0] OP_MOVRA = 4'h8;  // register -> accumulator
  localparam logic [3:0] OP_MOVAR = 4'h9;  // accumulator -> register
  localparam logic [3:0] OP_BNE   = 4'hA;
  localparam logic [3:0] OP_BLTZ  = 4'hB;
  localparam logic [3:0] OP_XOR   = 4'hC;
  localparam logic [3:0] OP_NOT   = 4'hD;
  localparam logic [3:0] OP_J     = 4'hE;
  localparam logic [3:0] OP_JAL   = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb
  } state_e;

  // ALU operations write both the accumulator and the status flags.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT};
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op inside {OP_RSV6, OP_RSV7};
  endfunction

endpackage

// File: rtl/instr_sequencer_pc_next_unit.sv
// Combinational next-pc logic for the sequencer.
// Ports:
//   pc_i          current program counter
//   instruction_i instruction register (opcode in [7:4], offset/target in [3:0])
//   alu_zero_i    ALU zero flag, bne is taken when low
//   alu_neg_i     ALU negative flag, bltz is taken when high
//   pc_inc_o      pc + 1 (sequential successor, also the jal link value)
//   pc_exec_o     pc to commit at the end of EXEC for the current opcode
// All arithmetic wraps modulo 2^ADDR_W.
module instr_sequencer_pc_next_unit
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [7:0]        instruction_i,
  input  logic              alu_zero_i,
  input  logic              alu_neg_i,
  output logic [ADDR_W-1:0] pc_inc_o,
  output logic [ADDR_W-1:0] pc_exec_o
);

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] jump_tgt;

  assign opcode     = instruction_i[7:4];
  assign pc_inc_o   = pc_i + ADDR_W'(1);
  // Branch offset is relative to the sequential successor, not the branch itself.
  assign branch_off = {{(ADDR_W-4){instruction_i[3]}}, instruction_i[3:0]};
  assign branch_tgt = pc_inc_o + branch_off;
  // Jumps stay inside the current 16-byte page.
  assign jump_tgt   = {pc_i[ADDR_W-1:4], instruction_i[3:0]};

  always_comb begin
    pc_exec_o = pc_inc_o;
    case (opcode)
      OP_BNE:       if (!alu_zero_i) pc_exec_o = branch_tgt;
      OP_BLTZ:      if (alu_neg_i)   pc_exec_o = branch_tgt;
      OP_J, OP_JAL: pc_exec_o = jump_tgt;
      default:      pc_exec_o = pc_inc_o;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for the 8-bit core.
// Owns pc and the instruction register. It walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB over a single-port req/ack memory and issues
// one-cycle Moore write strobes.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   run                   sequencer leaves IDLE only while high
//   mem_ack, mem_rdata    memory completion and read data
//   data_addr             load/store address from the register file
//   alu_zero, alu_neg     ALU flags for bne / bltz
//   mem_req/we/addr       memory request, store flag, address
//   instruction, pc       architectural state to the control decoder
//   acc_we, rf_we         accumulator / register file write strobes
//   status_we, link_we    status flag update / jal link (pc+1) write
//   illegal               one-cycle pulse on an undefined opcode
//   busy                  high in every state except IDLE
//   load_data             load buffer, the write data for rf_we in WB
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              alu_zero,
  input  logic              alu_neg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              acc_we,
  output logic              rf_we,
  output logic              status_we,
  output logic              link_we,
  output logic              illegal,
  output logic              busy,
  output logic [7:0]        load_data
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        instr_q;
  logic [7:0]        load_buf_q;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_exec;

  assign opcode = instr_q[7:4];

  instr_sequencer_pc_next_unit #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc_i          (pc_q),
    .instruction_i (instr_q),
    .alu_zero_i    (alu_zero),
    .alu_neg_i     (alu_neg),
    .pc_inc_o      (pc_inc),
    .pc_exec_o     (pc_exec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= 8'h00;
      load_buf_q <= 8'h00;
    end else begin
      case (state_q)
        StIdle: begin
          if (run) state_q <= StFetch;
        end
        StFetch: begin
          if (mem_ack) begin
            instr_q <= mem_rdata;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (opcode == OP_LOAD || opcode == OP_STORE) begin
            state_q <= StMem;
          end else if (is_illegal_op(opcode)) begin
            // Skip the bad instruction; always refetch regardless of run.
            pc_q    <= pc_inc;
            state_q <= StFetch;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          pc_q    <= pc_exec;
          state_q <= run ? StFetch : StIdle;
        end
        StMem: begin
          if (mem_ack) begin
            if (opcode == OP_STORE) begin
              pc_q    <= pc_inc;
              state_q <= run ? StFetch : StIdle;
            end else begin
              load_buf_q <= mem_rdata;
              state_q    <= StWb;
            end
          end
        end
        StWb: begin
          pc_q    <= pc_inc;
          state_q <= run ? StFetch : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore outputs: decoded only from state and the instruction register, so a
  // reset drops every request and strobe as soon as the state clears.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    acc_we    = 1'b0;
    rf_we     = 1'b0;
    status_we = 1'b0;
    link_we   = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      StDecode: begin
        illegal = is_illegal_op(opcode);
      end
      StExec: begin
        acc_we    = is_alu_op(opcode) || (opcode == OP_MOVRA);
        status_we = is_alu_op(opcode);
        rf_we     = (opcode == OP_MOVAR);
        link_we   = (opcode == OP_JAL);
      end
      StMem: begin
        mem_req  = 1'b1;
        mem_we   = (opcode == OP_STORE);
        mem_addr = data_addr;
      end
      StWb: begin
        rf_we = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign load_data   = load_buf_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle sequencer for the 8-bit processor core.
- Owns the program counter and the instruction register. Runs each instruction through fetch/decode/execute/memory/writeback over a shared single-port memory with a req/ack handshake.
- Issues one-cycle write strobes to the accumulator, register file and status flags.
- The existing per-opcode control decoder supplies ALU select and register addresses; this block decides when those take effect.

Parameters:
- ADDR_W, 8, width of pc and memory address.
- RESET_PC, 8'h00, pc value after reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- run  input  1  level; sequencer leaves IDLE only while high.
- mem_ack  input  1  memory completes current request this cycle.
- mem_rdata  input  8  read data, valid when mem_ack=1.
- data_addr  input  ADDR_W  load/store address from register file (reg_addr2 operand).
- alu_zero  input  1  ALU zero flag for bne.
- alu_neg  input  1  ALU negative flag for bltz.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = store, 0 = read; valid with mem_req.
- mem_addr  output  ADDR_W  request address.
- instruction  output  8  instruction register, feeds control decoder.
- pc  output  ADDR_W  program counter.
- acc_we  output  1  accumulator write strobe.
- rf_we  output  1  register file write strobe.
- status_we  output  1  status flag update strobe.
- link_we  output  1  jal link write (value pc+1).
- illegal  output  1  one-cycle pulse on undefined opcode.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Async reset (reset=0): state=IDLE, pc=RESET_PC, instruction=8'h00, all strobes/mem_req/mem_we/illegal=0, mem_addr=0. Reset mid-transaction drops mem_req immediately; the pending ack is ignored after release.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ack. On ack, instruction<=mem_rdata, go to DECODE. A zero-wait memory (ack in the same cycle) gives a 1-cycle fetch.
- DECODE (1 cycle), on opcode = instruction[7:4]:
  - 0100 load / 0101 store: go to MEM.
  - 0110/0111: illegal=1, pc<=pc+1, go to FETCH.
  - All others: go to EXEC.
- EXEC (1 cycle):
  - 0000-0011, 1100, 1101: acc_we=1, status_we=1, pc<=pc+1.
  - 1000 (R->Acc): acc_we=1, pc<=pc+1.
  - 1001 (Acc->R): rf_we=1, pc<=pc+1.
  - 1010 bne: taken if alu_zero=0.
  - 1011 bltz: taken if alu_neg=1.
  - Branch taken: pc<=pc+1+sext(instruction[3:0]). Not taken: pc<=pc+1.
  - 1110 j: pc<={pc[7:4], instruction[3:0]}.
  - 1111 jal: same target as j, plus link_we=1.
  - Next state: FETCH if run=1, else IDLE.
- MEM: mem_req=1, mem_addr=data_addr, mem_we=(opcode==0101). Hold until mem_ack.
  - Store: on ack, pc<=pc+1, go to FETCH/IDLE per run.
  - Load: on ack, latch mem_rdata into an internal load buffer, go to WB.
- WB (1 cycle): rf_we=1, pc<=pc+1, go to FETCH/IDLE per run.
- Latency with zero-wait memory: ALU/mov/branch/jump 3 cycles; store 3 cycles; load 4 cycles.
- Strobes are single-cycle and Moore-style (decoded from state and instruction). At most one of acc_we/rf_we is high in any cycle.
- mem_ack while mem_req=0 is ignored. mem_addr and mem_we are stable for the whole request.
- pc arithmetic is modulo 2^ADDR_W: 8'hFF+1 wraps to 8'h00, and a branch offset below 0 wraps.
- run deasserted mid-instruction: the instruction completes, then the sequencer parks in IDLE.

Decomposition:
- Shared package: opcode constants (OP_ADD..OP_JAL), state encoding, RESET_PC default.
- One natural sub-module: pc_next_unit, combinational. Computes pc+1, the branch target and the jump target, and selects among them by opcode and flags.

Test Plan:
- Zero-wait ALU op: reset release, run=1, mem[0]=8'h05 (add) -> acc_we and status_we high in cycle 3, pc=1, FETCH resumes in cycle 4.
- Wait states on load: mem[0]=8'h41, data_addr=8'h20, mem[0x20]=8'hA5, ack delayed 2 cycles on each access -> rf_we pulse exactly once with buffer=8'hA5, pc=1.
- Branches: bne 8'hAE at pc=0x10 with alu_zero=0 -> pc=0x0F. Same instruction with alu_zero=1 -> pc=0x11. bltz 8'hB3 with alu_neg=1 at pc=0x40 -> pc=0x44.
- Jump and wrap: jal 8'hF7 at pc=0x35 -> pc=0x37, link_we=1. Non-branch at pc=0xFF -> pc=0x00.
- Illegal opcode: 8'h62 -> illegal pulse one cycle, no acc_we/rf_we, pc+1.
- Reset mid-MEM: assert reset while mem_req=1 for a store -> mem_req=0 same cycle, state IDLE, pc=RESET_PC; a late ack after release causes no change.
